// File: rtl/mem_master.sv
// Single-outstanding memory master: one request becomes a one-cycle read/write
// strobe, a hold cycle for the memory to respond, then a one-cycle response pulse.
module mem_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [15:0]       txn_count,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] data_out
);

  typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                r_we;
  logic                r_read;
  logic                r_write;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [15:0]         r_txn_count;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_data_in;

  assign w_accept = (r_state == IDLE) && req_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = STROBE;
      STROBE:  w_next = HOLD;
      HOLD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_txn_count <= '0;
      r_address   <= '0;
      r_data_in   <= '0;
    end else begin
      r_state     <= w_next;
      // Strobes only ever rise on acceptance, so they last exactly the STROBE cycle
      r_read      <= w_accept && !req_we;
      r_write     <= w_accept && req_we;
      r_rsp_valid <= (r_state == HOLD);
      if (w_accept) begin
        r_address <= req_addr;
        r_data_in <= req_wdata;
        r_we      <= req_we;
      end
      if (r_state == HOLD) begin
        r_txn_count <= r_txn_count + 16'd1;
        if (!r_we) r_rsp_rdata <= data_out;
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign txn_count = r_txn_count;
  assign address   = r_address;
  assign data_in   = r_data_in;
  assign read      = r_read;
  assign write     = r_write;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: a table of single transactions plus hand-written
// sequences for back-to-back, busy masking, reset corners and counter wrap.
module tb_mem_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [15:0] txn_count;
  logic [7:0]  address;
  logic [15:0] data_in;
  logic        read;
  logic        write;
  logic [15:0] data_out;

  int checks = 0;
  int errors = 0;
  int strobe_viol = 0;

  logic [15:0] mem [256];
  logic        prev_read = 1'b0;
  logic        prev_write = 1'b0;

  mem_master #(.ADDR_W(8), .DATA_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .txn_count(txn_count), .address(address), .data_in(data_in),
    .read(read), .write(write), .data_out(data_out)
  );

  always #5 CLK = ~CLK;

  // Memory samples the strobe at the edge ending STROBE; read data is held until next read
  always @(posedge CLK) begin
    if (write) mem[address] <= data_in;
    if (read)  data_out <= mem[address];
  end

  always @(negedge CLK) begin
    if (read && write) strobe_viol++;
    if ((read && prev_read) || (write && prev_write)) strobe_viol++;
    prev_read  = read;
    prev_write = write;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive at negedge, one full transaction, checking every cycle of it
  task automatic do_txn(input logic we, input logic [7:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input logic [15:0] exp_cnt);
    chk("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("strobe_read", {31'd0, read}, {31'd0, !we});
    chk("strobe_write", {31'd0, write}, {31'd0, we});
    chk("address", {24'd0, address}, {24'd0, a});
    chk("data_in", {16'd0, data_in}, {16'd0, wd});
    chk("busy_strobe", {31'd0, busy}, 32'd1);
    @(negedge CLK);
    chk("hold_strobes", {30'd0, read, write}, 32'd0);
    chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("hold_address", {24'd0, address}, {24'd0, a});
    @(negedge CLK);
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rd});
    chk("txn_count", {16'd0, txn_count}, {16'd0, exp_cnt});
    chk("busy_done", {31'd0, busy}, 32'd0);
    @(negedge CLK);
    chk("rsp_valid_pulse", {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [6];
  logic exp_rd_seq [6];
  logic exp_rv_seq [6];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0321;
    mem[8'hFF] = 16'h0040;
    mem[8'hFE] = 16'h0020;
    data_out  = 16'h0000;

    vecs[0] = '{1'b0, 8'h00, 16'h0000, 16'h0321, 16'd1};
    vecs[1] = '{1'b1, 8'h10, 16'h55AA, 16'h0321, 16'd2};
    vecs[2] = '{1'b0, 8'h10, 16'h0000, 16'h55AA, 16'd3};
    vecs[3] = '{1'b1, 8'h20, 16'h1234, 16'h55AA, 16'd4};
    vecs[4] = '{1'b0, 8'h20, 16'hFFFF, 16'h1234, 16'd5};
    vecs[5] = '{1'b0, 8'hFF, 16'h0000, 16'h0040, 16'd6};

    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 16'h0000;
    repeat (3) @(negedge CLK);
    chk("rst_outputs", {rsp_valid, read, write, busy, rsp_rdata, txn_count, address, data_in},
        {4'b0000, 16'h0000, 16'h0000, 8'h00, 16'h0000});
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 6; i++)
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_count);

    // Back-to-back with req_valid held: second accept lands in the rsp_valid cycle
    exp_rd_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_rv_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (k == 0) req_addr = 8'hFE;
      if (k == 5) req_valid = 1'b0;
      chk($sformatf("b2b_read_%0d", k), {31'd0, read}, {31'd0, exp_rd_seq[k]});
      chk($sformatf("b2b_rsp_valid_%0d", k), {31'd0, rsp_valid}, {31'd0, exp_rv_seq[k]});
      if (k == 2) chk("b2b_rdata_1", {16'd0, rsp_rdata}, 32'h0040);
      if (k == 2) chk("b2b_addr_1", {24'd0, address}, 32'h00FF);
      if (k == 5) chk("b2b_rdata_2", {16'd0, rsp_rdata}, 32'h0020);
    end
    chk("b2b_count", {16'd0, txn_count}, 32'd8);
    @(negedge CLK);

    // Busy masking: request fields change while STROBE/HOLD, must be ignored
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00;
    @(negedge CLK);
    req_valid = 1'b0; req_addr = 8'h01; req_we = 1'b1; req_wdata = 16'hDEAD;
    chk("mask_addr_strobe", {24'd0, address}, 32'h0000);
    chk("mask_read", {30'd0, read, write}, 32'd2);
    @(negedge CLK);
    req_valid = 1'b1;
    chk("mask_addr_hold", {24'd0, address}, 32'h0000);
    chk("mask_no_write", {31'd0, write}, 32'd0);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("mask_rsp", {15'd0, rsp_valid, rsp_rdata}, {15'd0, 1'b1, 16'h0321});
    chk("mask_count", {16'd0, txn_count}, 32'd9);
    @(negedge CLK);

    // Reset coinciding with a valid request: nothing latched
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h33; req_wdata = 16'hBEEF; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; req_valid = 1'b0;
    chk("rst_accept", {write, read, busy, address, data_in}, {3'b000, 8'h00, 16'h0000});
    @(negedge CLK);
    chk("rst_accept_idle", {31'd0, busy}, 32'd0);

    // Reset during HOLD aborts the read
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    chk("midop_in_hold", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midop_rst", {rsp_valid, read, write, busy, rsp_rdata, txn_count, address, data_in},
        {4'b0000, 16'h0000, 16'h0000, 8'h00, 16'h0000});
    @(negedge CLK);
    chk("midop_no_rsp", {16'd0, rsp_valid, 15'd0, txn_count[0]}, 32'd0);

    // Counter wrap via preload
    force dut.r_txn_count = 16'hFFFF;
    @(negedge CLK);
    release dut.r_txn_count;
    @(negedge CLK);
    chk("wrap_preload", {16'd0, txn_count}, 32'h0000FFFF);
    do_txn(1'b0, 8'h00, 16'h0000, 16'h0321, 16'h0000);

    chk("strobe_rules", strobe_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL provide parameter DATA_W, default 16, memory data width.
REQ-003 SHALL provide port CLK, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL provide port RST, input, 1, synchronous active-high reset, sampled on CLK rising edge.
REQ-005 SHALL provide port req_valid, input, 1, requester has a transaction.
REQ-006 SHALL provide port req_ready, output, 1, block accepts a transaction this cycle.
REQ-007 SHALL provide port req_we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL provide port req_addr, input, ADDR_W, transaction address.
REQ-009 SHALL provide port req_wdata, input, DATA_W, write data.
REQ-010 SHALL provide port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL provide port rsp_rdata, output, DATA_W, read data; valid with rsp_valid on reads.
REQ-012 SHALL provide port busy, output, 1, transaction in progress (state != IDLE).
REQ-013 SHALL provide port txn_count, output, 16, completed-transaction counter.
REQ-014 SHALL provide port address, output, ADDR_W, memory address.
REQ-015 SHALL provide port data_in, output, DATA_W, memory write data.
REQ-016 SHALL provide port read, output, 1, memory read strobe.
REQ-017 SHALL provide port write, output, 1, memory write strobe.
REQ-018 SHALL provide port data_out, input, DATA_W, memory read data (may be high-Z between reads).

Function
REQ-019 SHALL implement FSM states IDLE, STROBE, HOLD; all outputs registered except req_ready and busy.
REQ-020 SHALL drive req_ready = 1 only in IDLE; a transaction is accepted on an edge where req_valid && req_ready.
REQ-021 On acceptance: latch req_addr into address, req_wdata into data_in, and req_we; assert write (if we) or read (else); IDLE -> STROBE.
REQ-022 SHALL keep read/write high for exactly one cycle (STROBE); STROBE -> HOLD unconditionally, strobe deasserted.
REQ-023 SHALL never assert read and write in the same cycle.
REQ-024 SHALL hold address and data_in stable from acceptance until the cycle after HOLD.
REQ-025 In HOLD on a read: capture data_out into rsp_rdata at the HOLD-exit edge; on a write, leave rsp_rdata unchanged.
REQ-026 HOLD -> IDLE unconditionally; rsp_valid = 1 for exactly the one cycle following the HOLD-exit edge.
REQ-027 Latency: acceptance at edge E0; memory operates at E1; capture at E2; rsp_valid high in cycle after E2.
REQ-028 Throughput: one transaction per 3 cycles; back-to-back acceptance allowed in the cycle rsp_valid is high.
REQ-029 SHALL ignore req_valid, req_we, req_addr and req_wdata while busy.
REQ-030 SHALL increment txn_count by 1 at each HOLD-exit edge, wrapping 0xFFFF -> 0x0000.
REQ-031 Strobe low for at least 2 cycles between strobes, guaranteeing a fresh rising edge per transaction.

Reset
REQ-032 On RST: state = IDLE; read = 0; write = 0; rsp_valid = 0; rsp_rdata = 0; address = 0; data_in = 0; txn_count = 0.
REQ-033 Reset overrides a simultaneous acceptance; no transaction latched that cycle.
REQ-034 Reset mid-transaction aborts it with no rsp_valid and no txn_count increment; a strobe already issued may still complete at the memory.

Verification
REQ-035 Read: bench memory preloaded 0x00=0x0321; request read addr 0x00 -> read high 1 cycle after E0; rsp_valid in cycle after E2; rsp_rdata = 0x0321; txn_count = 1.
REQ-036 Write then read: write 0x55AA to 0x10, then read 0x10 -> write high 1 cycle, data_in = 0x55AA; read returns 0x55AA; txn_count = 2.
REQ-037 Back-to-back: req_valid held high; reads of 0xFF, 0xFE -> rsp_rdata 0x0040 then 0x0020; rsp_valid pulses 3 cycles apart; read never high 2 consecutive cycles.
REQ-038 Busy masking: change req_addr to 0x01 during STROBE/HOLD of a read of 0x00 -> address stays 0x00; rsp_rdata = 0x0321.
REQ-039 Reset mid-op: assert RST during HOLD -> next cycle all outputs at reset values; no rsp_valid; txn_count = 0.
REQ-040 Counter wrap: force 65536 completions (or preload 0xFFFF) -> txn_count reads 0x0000 after the next completion.
